// File: rtl/axis_demux_pkg.sv
// Shared types and helpers for the AXI4-Stream tdest demultiplexer.
// Holds the routing FSM encoding and the channel-range check used on packet heads.
package axis_demux_pkg;

  localparam int MAX_CH = 4;

  typedef enum logic [1:0] {
    e_sop  = 2'd0,
    e_fwd  = 2'd1,
    e_drop = 2'd2
  } state_e;

  // True when tdest names an existing output channel.
  function automatic logic dest_in_range(input logic [31:0] dest, input int num_ch);
    return dest < 32'(num_ch);
  endfunction

endpackage

// File: rtl/ofs_axis_if.sv
// AXI4-Stream bundle with full sideband; source drives payload, sink drives tready.
interface ofs_axis_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic                       tlast;
  logic [TID_WIDTH-1:0]       tid;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic [TUSER_WIDTH-1:0]     tuser;

  modport source (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport sink   (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_skid_reg.sv
// Two-entry AXI4-Stream skid buffer. s_tready is a flop, so upstream never sees
// a combinational path from m_tready.
module axis_skid_reg #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                     s_tlast,
  input  logic [TID_WIDTH-1:0]     s_tid,
  input  logic [TDEST_WIDTH-1:0]   s_tdest,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TID_WIDTH-1:0]     m_tid,
  output logic [TDEST_WIDTH-1:0]   m_tdest,
  output logic [TUSER_WIDTH-1:0]   m_tuser
);
  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int BUS_W  = TDATA_WIDTH + KEEP_W + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  logic [BUS_W-1:0] mem_q [2];
  logic [BUS_W-1:0] s_bus;
  logic [BUS_W-1:0] m_bus;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             push;
  logic             pop;

  assign s_bus = {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
  assign push  = s_tvalid & ready_q;
  assign pop   = m_tready & (cnt_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    ready_d  = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_bus;
  end

  assign m_bus    = mem_q[rd_ptr_q];
  assign m_tvalid = (cnt_q != 2'd0);
  assign s_tready = ready_q;
  assign {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = m_bus;

endmodule

// File: rtl/axis_demux.sv
// AXI4-Stream packet demultiplexer: the first beat's tdest picks an output channel
// that is held until tlast; packets for non-existent channels are dropped and counted.
module axis_demux
  import axis_demux_pkg::*;
#(
  parameter int NUM_CH         = 1,
  parameter int TDATA_WIDTH    = 8,
  parameter int TID_WIDTH      = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TUSER_WIDTH    = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  ofs_axis_if.sink                  sink,
  ofs_axis_if.source                source [NUM_CH-1:0],
  output logic                      drop_pulse,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NSLOT  = 2 ** CH_W;
  localparam int BUS_W  = TDATA_WIDTH + KEEP_W + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  logic                   h_tvalid;
  logic                   h_pop;
  logic [TDATA_WIDTH-1:0] h_tdata;
  logic [KEEP_W-1:0]      h_tkeep;
  logic                   h_tlast;
  logic [TID_WIDTH-1:0]   h_tid;
  logic [TDEST_WIDTH-1:0] h_tdest;
  logic [TUSER_WIDTH-1:0] h_tuser;
  logic [BUS_W-1:0]       h_bus;
  logic                   h_in_range;
  logic [CH_W-1:0]        h_ch;

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]        fwd_ch;
  logic                   fwd_en;
  logic                   drop_last;

  logic [NSLOT-1:0]       out_ready;
  logic [NUM_CH-1:0]      out_tready;
  logic [NUM_CH-1:0]      out_load;
  logic [NUM_CH-1:0]      out_valid_q, out_valid_d;
  logic [BUS_W-1:0]       payload_q [NUM_CH];

  logic                      drop_pulse_q, drop_pulse_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  axis_skid_reg #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .TID_WIDTH   (TID_WIDTH),
    .TDEST_WIDTH (TDEST_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (sink.tvalid),
    .s_tready (sink.tready),
    .s_tdata  (sink.tdata),
    .s_tkeep  (sink.tkeep),
    .s_tlast  (sink.tlast),
    .s_tid    (sink.tid),
    .s_tdest  (sink.tdest),
    .s_tuser  (sink.tuser),
    .m_tvalid (h_tvalid),
    .m_tready (h_pop),
    .m_tdata  (h_tdata),
    .m_tkeep  (h_tkeep),
    .m_tlast  (h_tlast),
    .m_tid    (h_tid),
    .m_tdest  (h_tdest),
    .m_tuser  (h_tuser)
  );

  assign h_bus      = {h_tdata, h_tkeep, h_tlast, h_tid, h_tdest, h_tuser};
  assign h_in_range = dest_in_range(32'(h_tdest), NUM_CH);
  assign h_ch       = h_tdest[CH_W-1:0];

  // out_ready is padded to a power of two so an unused h_ch slot reads as not ready.
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_ready
    if (gi < NUM_CH) begin : g_real
      assign out_tready[gi] = source[gi].tready;
      assign out_ready[gi]  = ~out_valid_q[gi] | source[gi].tready;
    end else begin : g_pad
      assign out_ready[gi] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    fwd_ch    = cur_ch_q;
    fwd_en    = 1'b0;
    h_pop     = 1'b0;
    drop_last = 1'b0;
    case (state_q)
      e_sop: begin
        if (h_tvalid) begin
          if (h_in_range) begin
            fwd_ch = h_ch;
            if (out_ready[h_ch]) begin
              h_pop    = 1'b1;
              fwd_en   = 1'b1;
              cur_ch_d = h_ch;
              if (!h_tlast) state_d = e_fwd;
            end
          end else begin
            h_pop = 1'b1;
            if (h_tlast) drop_last = 1'b1;
            else         state_d   = e_drop;
          end
        end
      end
      e_fwd: begin
        if (h_tvalid && out_ready[cur_ch_q]) begin
          h_pop  = 1'b1;
          fwd_en = 1'b1;
          if (h_tlast) state_d = e_sop;
        end
      end
      e_drop: begin
        if (h_tvalid) begin
          h_pop = 1'b1;
          if (h_tlast) begin
            drop_last = 1'b1;
            state_d   = e_sop;
          end
        end
      end
      default: state_d = e_sop;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      out_load[i]    = fwd_en && (fwd_ch == CH_W'(i));
      out_valid_d[i] = out_load[i] | (out_valid_q[i] & ~out_tready[i]);
    end
  end

  always_comb begin
    drop_pulse_d = drop_last;
    drop_cnt_d   = drop_cnt_q;
    if (drop_last && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= e_sop;
      cur_ch_q     <= '0;
      out_valid_q  <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      out_valid_q  <= out_valid_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
    always_ff @(posedge clk) begin
      if (out_load[gi]) payload_q[gi] <= h_bus;
    end
    assign source[gi].tvalid = out_valid_q[gi];
    assign {source[gi].tdata, source[gi].tkeep, source[gi].tlast,
            source[gi].tid, source[gi].tdest, source[gi].tuser} = payload_q[gi];
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_axis_demux.sv
// Randomised bench for axis_demux: a packet-level scoreboard predicts each channel's
// beat sequence and the saturating drop count from the first-beat routing rule.
module tb_axis_demux;
  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int IDW    = 2;
  localparam int DSTW   = 3;
  localparam int USW    = 2;
  localparam int DCW    = 2;
  localparam int DMAX   = (1 << DCW) - 1;

  typedef struct packed {
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic [IDW-1:0]  tid;
    logic [DSTW-1:0] tdest;
    logic [USW-1:0]  tuser;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ofs_axis_if #(.TDATA_WIDTH(DW), .TID_WIDTH(IDW), .TDEST_WIDTH(DSTW), .TUSER_WIDTH(USW)) sink_if ();
  ofs_axis_if #(.TDATA_WIDTH(DW), .TID_WIDTH(IDW), .TDEST_WIDTH(DSTW), .TUSER_WIDTH(USW)) src_if [NUM_CH-1:0] ();

  logic           drop_pulse;
  logic [DCW-1:0] drop_cnt;

  axis_demux #(
    .NUM_CH(NUM_CH), .TDATA_WIDTH(DW), .TID_WIDTH(IDW),
    .TDEST_WIDTH(DSTW), .TUSER_WIDTH(USW), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sink       (sink_if),
    .source     (src_if),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  logic  in_valid = 1'b0;
  beat_t in_beat  = '0;
  assign sink_if.tvalid = in_valid;
  assign sink_if.tdata  = in_beat.tdata;
  assign sink_if.tkeep  = in_beat.tkeep;
  assign sink_if.tlast  = in_beat.tlast;
  assign sink_if.tid    = in_beat.tid;
  assign sink_if.tdest  = in_beat.tdest;
  assign sink_if.tuser  = in_beat.tuser;

  logic [NUM_CH-1:0] src_tvalid;
  logic [NUM_CH-1:0] src_tready = '1;
  beat_t             src_beat [NUM_CH];
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_src
    assign src_tvalid[gi]   = src_if[gi].tvalid;
    assign src_if[gi].tready = src_tready[gi];
    assign src_beat[gi] = {src_if[gi].tdata, src_if[gi].tkeep, src_if[gi].tlast,
                           src_if[gi].tid, src_if[gi].tdest, src_if[gi].tuser};
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: per-channel expected beats plus packet/drop bookkeeping.
  beat_t exp_q [NUM_CH][$];
  bit    in_pkt      = 1'b0;
  int    pkt_ch      = 0;
  int    exp_drops   = 0;
  int    drops_total = 0;
  int    pulses_seen = 0;
  int    cyc         = 0;
  bit    lat_arm     = 1'b0;
  int    lat_in      = -1;
  int    lat_out     = -1;

  bit                rand_ready = 1'b0;
  bit                gap_en     = 1'b0;
  logic [NUM_CH-1:0] hold       = '0;

  initial forever begin
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++)
      src_tready[c] = hold[c] ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
      in_pkt      = 1'b0;
      exp_drops   = 0;
      drops_total = 0;
      pulses_seen = 0;
    end else begin
      if (in_valid && sink_if.tready) begin
        if (lat_arm && lat_in < 0) lat_in = cyc;
        if (!in_pkt) begin
          pkt_ch = (int'(in_beat.tdest) < NUM_CH) ? int'(in_beat.tdest) : -1;
          in_pkt = 1'b1;
        end
        if (pkt_ch >= 0) exp_q[pkt_ch].push_back(in_beat);
        if (in_beat.tlast) begin
          in_pkt = 1'b0;
          if (pkt_ch < 0) begin
            drops_total++;
            if (exp_drops < DMAX) exp_drops++;
          end
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (src_tvalid[c] && lat_arm && lat_out < 0) lat_out = cyc;
        if (src_tvalid[c] && src_tready[c]) begin
          check_val($sformatf("ch%0d_beat_expected", c), 32'(exp_q[c].size() > 0), 32'(1));
          if (exp_q[c].size() > 0)
            check_val($sformatf("ch%0d_beat", c), 32'(src_beat[c]), 32'(exp_q[c].pop_front()));
        end
      end
      if (drop_pulse) pulses_seen++;
    end
    if (!lat_arm) begin
      lat_in  = -1;
      lat_out = -1;
    end
  end

  function automatic beat_t mk_beat(input logic [DSTW-1:0] dest, input logic last);
    beat_t b;
    b.tdata = DW'($urandom);
    b.tkeep = (DW/8)'($urandom);
    b.tlast = last;
    b.tid   = IDW'($urandom);
    b.tdest = dest;
    b.tuser = USW'($urandom);
    return b;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_beat(input beat_t b);
    in_beat  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sink_if.tready) break;
      if (t == 299) check_val("sink_accept", 32'(sink_if.tready), 32'(1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_pkt(input int dest, input int len, input int mid_dest);
    int d;
    for (int i = 0; i < len; i++) begin
      if (i == 0)            d = dest;
      else if (mid_dest >= 0) d = mid_dest;
      else                   d = int'($urandom_range(0, 7));
      send_beat(mk_beat(DSTW'(d), i == len - 1));
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < NUM_CH; c++) n += exp_q[c].size();
    return n;
  endfunction

  task automatic drain(input string tag);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (pending() == 0) break;
    end
    repeat (4) @(negedge clk);
    check_val({tag, "_drained"}, 32'(pending()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++)
      check_val($sformatf("%s_tvalid%0d", tag, c), 32'(src_tvalid[c]), 32'(0));
    check_val({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(0));
    check_val({tag, "_sink_tready"}, 32'(sink_if.tready), 32'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    bit saw_stall;

    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // 1: single 3-beat packet to channel 2, latency from sink handshake to output
    lat_arm = 1'b1;
    send_pkt(2, 3, -1);
    drain("t1");
    check_val("t1_latency", 32'(lat_out - lat_in), 32'(2));
    lat_arm = 1'b0;
    check_val("t1_drop_cnt", 32'(drop_cnt), 32'(0));

    // 2: mid-packet tdest change ignored, then single-beat to channel 3
    send_pkt(1, 4, 0);
    send_pkt(3, 1, -1);
    drain("t2");

    // 3: out-of-range tdest packets are dropped and counted
    send_pkt(5, 2, -1);
    send_pkt(5, 1, -1);
    drain("t3");
    check_val("t3_drop_cnt", 32'(drop_cnt), 32'(2));
    check_val("t3_pulses", 32'(pulses_seen), 32'(drops_total));

    // 4: stalled channel 0 backs up the input and blocks channel 1
    hold[0] = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        send_pkt(0, 6, -1);
        send_pkt(1, 2, -1);
      end
      begin
        saw_stall = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (!sink_if.tready) saw_stall = 1'b1;
        end
        check_val("t4_sink_stall", 32'(saw_stall), 32'(1));
        check_val("t4_ch0_holding", 32'(src_tvalid[0]), 32'(1));
        check_val("t4_hol_ch1", 32'(src_tvalid[1]), 32'(0));
        hold[0] = 1'b0;
      end
    join
    drain("t4");

    // 5: reset in the middle of a packet, then a fresh packet
    for (int i = 0; i < 3; i++) send_beat(mk_beat(DSTW'(2), 1'b0));
    do_reset("t5");
    send_pkt(1, 3, -1);
    drain("t5");

    // Randomised traffic with random backpressure and idle gaps
    rand_ready = 1'b1;
    gap_en     = 1'b1;
    for (int p = 0; p < 250; p++)
      send_pkt(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), -1);
    rand_ready = 1'b0;
    gap_en     = 1'b0;
    drain("rand");
    check_val("rand_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    check_val("rand_pulses", 32'(pulses_seen), 32'(drops_total));

    // 6: drop counter saturation
    do_reset("t6");
    for (int k = 0; k < 5; k++) begin
      send_pkt(6, 1, -1);
      drain("t6");
      check_val($sformatf("t6_drop_cnt_%0d", k), 32'(drop_cnt), 32'(sat_exp[k]));
    end
    check_val("t6_pulses", 32'(pulses_seen), 32'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
